vga_layer_compositor: RTL and testbench

Parametrised successor to the current VGA front end. It combines the pixel-clock divider, the H/V timing counters, the sync comparators and the colour mux in one block. The block composites `N_LAYERS` solid-colour rectangles with fixed priority over a background colour. Layer geometry is shadow-latched once per frame so that updates never tear. It sits between the game-state logic (walls, scrolls, player, destination rect) and the VGA pins.

---
 rtl/vga_layer_compositor.sv | 200 ++++++++++++++++++++
 tb/tb_vga_layer_compositor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor.sv
// VGA timing generator and N-layer solid-rectangle compositor with per-frame shadowed geometry.
// Optional output dimming is enabled by defining VIDEO_DIM_EN.
module vga_layer_compositor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int N_LAYERS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [12*N_LAYERS-1:0] layer_x,
    input  logic [12*N_LAYERS-1:0] layer_y,
    input  logic [12*N_LAYERS-1:0] layer_w,
    input  logic [12*N_LAYERS-1:0] layer_h,
    input  logic [12*N_LAYERS-1:0] layer_color,
    input  logic [N_LAYERS-1:0]    layer_visible,
    input  logic [11:0]            bg_color,
    input  logic [1:0]             dim,
    output logic                   HS,
    output logic                   VS,
    output logic [3:0]             vgaRed,
    output logic [3:0]             vgaGreen,
    output logic [3:0]             vgaBlue,
    output logic [11:0]            hcount,
    output logic [11:0]            vcount,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic [11:0]      h_cnt;
    logic [11:0]      v_cnt;
    logic             frame_end;

    logic [11:0]         sh_x     [N_LAYERS];
    logic [11:0]         sh_y     [N_LAYERS];
    logic [11:0]         sh_w     [N_LAYERS];
    logic [11:0]         sh_h     [N_LAYERS];
    logic [11:0]         sh_color [N_LAYERS];
    logic [N_LAYERS-1:0] sh_vis;

    logic                hs0, vs0, active0;
    logic [N_LAYERS-1:0] hit_d, hit_q;
    logic                hs1, vs1, active1;
    logic [11:0]         col_sel, col_out, col_q;
    logic                hs2, vs2;

    // With CLK_DIV=1 the divider is stuck at 0 == DIV_LAST, so pix_en is constant 1.
    assign pix_en    = (div_cnt == DIV_LAST);
    assign frame_end = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
        end
    end

    // Geometry is captured only at the last pixel of the frame so a frame never mixes old and new layouts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                sh_x[i]     <= '0;
                sh_y[i]     <= '0;
                sh_w[i]     <= '0;
                sh_h[i]     <= '0;
                sh_color[i] <= '0;
            end
            sh_vis <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                sh_x[i]     <= layer_x[12*i +: 12];
                sh_y[i]     <= layer_y[12*i +: 12];
                sh_w[i]     <= layer_w[12*i +: 12];
                sh_h[i]     <= layer_h[12*i +: 12];
                sh_color[i] <= layer_color[12*i +: 12];
            end
            sh_vis <= layer_visible;
        end
    end

    always_comb begin
        hs0     = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs0     = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
        active0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    end

    // Right/bottom edges are summed at 13 bits so large x+w never wraps back into view.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            hit_d[i] = sh_vis[i]
                && (h_cnt >= sh_x[i])
                && ({1'b0, h_cnt} < ({1'b0, sh_x[i]} + {1'b0, sh_w[i]}))
                && (v_cnt >= sh_y[i])
                && ({1'b0, v_cnt} < ({1'b0, sh_y[i]} + {1'b0, sh_h[i]}));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q   <= '0;
            hs1     <= ~SYNC_POL;
            vs1     <= ~SYNC_POL;
            active1 <= 1'b0;
        end else if (pix_en) begin
            hit_q   <= hit_d;
            hs1     <= hs0;
            vs1     <= vs0;
            active1 <= active0;
        end
    end

    // Walking from the highest index down leaves the lowest-index hit as the winner.
    always_comb begin
        col_sel = bg_color;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                col_sel = sh_color[i];
            end
        end
        if (!active1) begin
            col_sel = '0;
        end
    end

`ifdef VIDEO_DIM_EN
    assign col_out = {col_sel[11:8] >> dim, col_sel[7:4] >> dim, col_sel[3:0] >> dim};
`else
    logic unused_dim;
    assign unused_dim = ^dim;
    assign col_out    = col_sel;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            hs2   <= ~SYNC_POL;
            vs2   <= ~SYNC_POL;
        end else if (pix_en) begin
            col_q <= col_out;
            hs2   <= hs1;
            vs2   <= vs1;
        end
    end

    assign HS       = hs2;
    assign VS       = vs2;
    assign vgaRed   = col_q[11:8];
    assign vgaGreen = col_q[7:4];
    assign vgaBlue  = col_q[3:0];
    assign hcount   = h_cnt;
    assign vcount   = v_cnt;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor on a reduced 24x17 raster (16x12 visible, 4 clks/pixel).
// Colour expectations account for dim=2 when VIDEO_DIM_EN is defined.
module tb_vga_layer_compositor;

    localparam int NL = 4;
    localparam int FRAME_CLKS = 24 * 17 * 4;
    localparam int WAIT_MAX = 4000;

    logic            clk = 1'b0;
    logic            rst;
    logic [12*NL-1:0] layer_x, layer_y, layer_w, layer_h, layer_color;
    logic [NL-1:0]   layer_visible;
    logic [11:0]     bg_color;
    logic [1:0]      dim;
    logic            hs_pin, vs_pin;
    logic [3:0]      vga_red, vga_green, vga_blue;
    logic [11:0]     hcount, vcount;
    logic            frame_start;
    logic [11:0]     rgb;

    int checks_total = 0;
    int checks_passed = 0;

    assign rgb = {vga_red, vga_green, vga_blue};

    always #5 clk = ~clk;

    vga_layer_compositor #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .CLK_DIV(4), .N_LAYERS(NL)
    ) dut (
        .clk(clk), .rst(rst),
        .layer_x(layer_x), .layer_y(layer_y), .layer_w(layer_w), .layer_h(layer_h),
        .layer_color(layer_color), .layer_visible(layer_visible),
        .bg_color(bg_color), .dim(dim),
        .HS(hs_pin), .VS(vs_pin),
        .vgaRed(vga_red), .vgaGreen(vga_green), .vgaBlue(vga_blue),
        .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
    );

    function automatic logic [11:0] shown(input logic [11:0] c);
`ifdef VIDEO_DIM_EN
        return {c[11:8] >> 2, c[7:4] >> 2, c[3:0] >> 2};
`else
        return c;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic set_layer(input int idx, input logic [11:0] x, input logic [11:0] y,
                             input logic [11:0] w, input logic [11:0] h,
                             input logic [11:0] color, input logic vis);
        layer_x[12*idx +: 12]     = x;
        layer_y[12*idx +: 12]     = y;
        layer_w[12*idx +: 12]     = w;
        layer_h[12*idx +: 12]     = h;
        layer_color[12*idx +: 12] = color;
        layer_visible[idx]        = vis;
    endtask

    task automatic wait_counter(input int h, input int v);
        int n;
        for (n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk);
            if (hcount == 12'(h) && vcount == 12'(v)) break;
        end
        if (n == WAIT_MAX) checkOutput("counter_timeout", 32'(n), 0);
    endtask

    // Pins show pixel (h,v) while the counter sits at (h+2,v).
    task automatic goto_pixel(input int h, input int v);
        wait_counter(h + 2, v);
    endtask

    task automatic wait_frame();
        int n;
        for (n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk);
            if (frame_start) break;
        end
        if (n == WAIT_MAX) checkOutput("frame_timeout", 32'(n), 0);
    endtask

    task automatic applyStimulus_pixel(input string tag, input int h, input int v, input logic [11:0] exp);
        goto_pixel(h, v);
        checkOutput(tag, 32'(rgb), 32'(exp));
    endtask

    initial begin
        int n;
        logic [11:0] bg;
        rst = 1'b0;
        layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0;
        layer_color = '0; layer_visible = '0;
        bg_color = 12'h00F;
        dim = 2'd2;
        bg = shown(12'h00F);

        repeat (3) @(negedge clk);
        checkOutput("rst_hcount", 32'(hcount), 0);
        checkOutput("rst_vcount", 32'(vcount), 0);
        checkOutput("rst_hs", 32'(hs_pin), 1);
        checkOutput("rst_vs", 32'(vs_pin), 1);
        checkOutput("rst_rgb", 32'(rgb), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("release_h_hold", 32'(hcount), 0);
        @(negedge clk);
        checkOutput("release_h_first", 32'(hcount), 1);

        wait_frame();
        checkOutput("fs_at_origin", 32'({hcount, vcount}), 0);
        @(negedge clk);
        checkOutput("fs_width", 32'(frame_start), 0);
        n = 1;
        while (!frame_start && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fs_period", 32'(n), 32'(FRAME_CLKS));

        goto_pixel(5, 3);  checkOutput("bg_active", 32'(rgb), 32'(bg));
        goto_pixel(16, 3); checkOutput("bg_hblank", 32'(rgb), 0);
        goto_pixel(17, 3); checkOutput("hs_before", 32'(hs_pin), 1);
        goto_pixel(18, 3); checkOutput("hs_start", 32'(hs_pin), 0);
        goto_pixel(20, 3); checkOutput("hs_last", 32'(hs_pin), 0);
        goto_pixel(21, 3); checkOutput("hs_after", 32'(hs_pin), 1);
        goto_pixel(0, 12); checkOutput("vs_before", 32'(vs_pin), 1);
        checkOutput("bg_vblank", 32'(rgb), 0);
        goto_pixel(0, 13); checkOutput("vs_start", 32'(vs_pin), 0);
        goto_pixel(0, 14); checkOutput("vs_last", 32'(vs_pin), 0);
        goto_pixel(0, 15); checkOutput("vs_after", 32'(vs_pin), 1);

        wait_counter(23, 5);
        while (hcount == 12'd23) @(negedge clk);
        checkOutput("hwrap", 32'({hcount, vcount}), 32'({12'd0, 12'd6}));
        wait_counter(23, 16);
        while (hcount == 12'd23) @(negedge clk);
        checkOutput("vwrap", 32'({hcount, vcount}), 0);

        set_layer(0, 12'd4, 12'd2, 12'd3, 12'd2, 12'hF00, 1'b1);
        wait_frame();
        applyStimulus_pixel("l0_above", 4, 1, bg);
        applyStimulus_pixel("l0_left", 3, 2, bg);
        applyStimulus_pixel("l0_corner", 4, 2, shown(12'hF00));
        applyStimulus_pixel("l0_right", 7, 2, bg);
        applyStimulus_pixel("l0_inner", 6, 3, shown(12'hF00));
        applyStimulus_pixel("l0_below", 4, 4, bg);

        set_layer(0, 12'd9, 12'd7, 12'd3, 12'd3, 12'h0F0, 1'b1);
        set_layer(1, 12'd2, 12'd2, 12'd0, 12'd5, 12'h0F0, 1'b1);
        set_layer(2, 12'd14, 12'd0, 12'd5, 12'd12, 12'hFF0, 1'b1);
        set_layer(3, 12'd10, 12'd8, 12'd1, 12'd1, 12'hF00, 1'b1);
        wait_frame();
        applyStimulus_pixel("w0_hidden", 2, 3, bg);
        applyStimulus_pixel("prio_l0_only", 9, 7, shown(12'h0F0));
        applyStimulus_pixel("prio_l0_wins", 10, 8, shown(12'h0F0));
        applyStimulus_pixel("clip_inside", 15, 8, shown(12'hFF0));
        applyStimulus_pixel("clip_outside", 16, 8, 0);
        layer_visible[0] = 1'b0;
        wait_frame();
        applyStimulus_pixel("prio_l0_off", 9, 7, bg);
        applyStimulus_pixel("prio_l3_shows", 10, 8, shown(12'hF00));

        layer_visible = '0;
        set_layer(0, 12'd4, 12'd0, 12'd2, 12'd12, 12'hF00, 1'b1);
        wait_frame();
        wait_counter(0, 5);
        layer_x[11:0] = 12'd10;
        applyStimulus_pixel("shadow_old_x", 4, 8, shown(12'hF00));
        applyStimulus_pixel("shadow_new_x_not_yet", 10, 8, bg);
        wait_frame();
        applyStimulus_pixel("shadow_old_gone", 4, 2, bg);
        applyStimulus_pixel("shadow_new_x", 10, 2, shown(12'hF00));

        set_layer(2, 12'd0, 12'd0, 12'd16, 12'd12, 12'h0F0, 1'b1);
        wait_frame();
        applyStimulus_pixel("pre_reset", 8, 6, shown(12'h0F0));
        #1 rst = 1'b0;
        #1;
        checkOutput("async_hcount", 32'(hcount), 0);
        checkOutput("async_vcount", 32'(vcount), 0);
        checkOutput("async_rgb", 32'(rgb), 0);
        checkOutput("async_sync", 32'({hs_pin, vs_pin}), 32'h3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus_pixel("post_reset_bg", 5, 3, bg);
        wait_frame();
        applyStimulus_pixel("post_reset_relatch", 5, 3, shown(12'h0F0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
